// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state
// encoding, default base address, NOP instruction and bus-width macros.
`ifndef IMEM_RESPONDER_PKG_SV
`define IMEM_RESPONDER_PKG_SV

`ifndef REG_BUS
`define REG_BUS 64
`endif

`ifndef IMEM_ADDR_W
`define IMEM_ADDR_W `REG_BUS
`endif

package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0]             NOP_INST_DEF  = 32'h0000_0013;
  localparam logic [`IMEM_ADDR_W-1:0] BASE_ADDR_DEF = 64'h0000_0000_8000_0000;

endpackage

`endif

// File: rtl/imem_responder_store.sv
// DEPTH x 32 instruction store: one synchronous write port and one
// asynchronous read port with write-first bypass on a same-word write.
module imem_store
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Preload / runtime write of one word per cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read with bypass so a write in the same cycle is seen immediately.
  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a fetch PC, returns the 32-bit
// instruction word LATENCY cycles later, flags misaligned/out-of-range
// fetches with NOP_INST. Define IMEM_RESP_LASTBUF_EN to add a one-entry
// last-fetch buffer that answers a repeated PC in one cycle.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter logic [`IMEM_ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned             DEPTH     = 1024,
  parameter int unsigned             LATENCY   = 2,
  parameter logic [31:0]             NOP_INST  = NOP_INST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [`IMEM_ADDR_W-1:0]  req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     load_ena,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              fetch_cnt
);

  localparam int unsigned             AW   = $clog2(DEPTH);
  // WAIT spans LATENCY-1 cycles and its last cycle is the sample cycle,
  // so the counter starts at LATENCY-2 and resp_valid lands at T+LATENCY.
  localparam logic [3:0]              CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [`IMEM_ADDR_W-1:0] SPAN = `IMEM_ADDR_W'(DEPTH) << 2;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [`IMEM_ADDR_W-1:0] addr_q;
  logic                    resp_valid_q;
  logic [31:0]             resp_inst_q;
  logic                    resp_err_q;
  logic [31:0]             fetch_cnt_q;

  logic [`IMEM_ADDR_W-1:0] look_addr;
  logic [`IMEM_ADDR_W-1:0] off;
  logic                    hit;
  logic [AW-1:0]           rd_idx;
  logic [31:0]             rd_data;
  logic                    accept;
  logic                    sample;
  logic                    buf_take;
  logic [31:0]             buf_data;

  // Decode the address being looked up: the live PC in the accept cycle,
  // the latched PC while waiting.
  always_comb begin
    look_addr = (state_q == IDLE) ? req_addr : addr_q;
    off       = look_addr - BASE_ADDR;
    hit       = (look_addr >= BASE_ADDR) && (off < SPAN) && (look_addr[1:0] == 2'b00);
    rd_idx    = off[AW+1:2];
  end

  imem_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .we_i    (load_ena),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

`ifdef IMEM_RESP_LASTBUF_EN
  logic                    buf_valid_q;
  logic [`IMEM_ADDR_W-1:0] buf_tag_q;
  logic [31:0]             buf_data_q;
  logic                    load_to_buf;

  // A load to the buffered word (even in the accept cycle) defeats the shortcut.
  always_comb begin
    load_to_buf = load_ena &&
                  (buf_tag_q == BASE_ADDR + {{(`IMEM_ADDR_W-2-AW){1'b0}}, load_addr, 2'b00});
    buf_take    = buf_valid_q && (req_addr == buf_tag_q) && !load_to_buf;
    buf_data    = buf_data_q;
  end

  // Capture every successful sampled response; invalidate on a store write to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
    end else if (sample && hit) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= look_addr;
      buf_data_q  <= rd_data;
    end else if (load_to_buf) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  // Without the buffer every request takes the full latency.
  always_comb begin
    buf_take = 1'b0;
    buf_data = '0;
  end
`endif

  // Accept and sample strobes for the FSM and the buffer.
  always_comb begin
    accept = (state_q == IDLE) && req_valid;
    sample = ((state_q == WAIT) && (cnt_q == 4'd0)) ||
             (accept && !buf_take && (LATENCY == 1));
  end

  // Request/response FSM with registered response outputs and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            cnt_q  <= CNT_INIT;
            if (buf_take) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= buf_data;
              resp_err_q   <= 1'b0;
            end else if (sample) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= hit ? rd_data : NOP_INST;
              resp_err_q   <= !hit;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_inst_q  <= hit ? rd_data : NOP_INST;
            resp_err_q   <= !hit;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            fetch_cnt_q  <= fetch_cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule
